// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared exception codes, width codes, FSM states and region helpers
package mem_arbiter_pkg;
  localparam int EXC_W = 4;
  localparam logic [EXC_W-1:0] EXCEP_OK = 4'h0;
  localparam logic [EXC_W-1:0] EXCEP_ACCESS_FAULT = 4'h5;
  localparam logic [EXC_W-1:0] EXCEP_BUS_TIMEOUT = 4'h6;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam logic [1:0] W_ILLEGAL = 2'd3;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic logic in_rgn(input logic [31:0] a, input logic [31:0] base, input logic [31:0] size);
    return (a >= base) && ((a - base) < size);
  endfunction
  function automatic logic overlap(input logic [31:0] ab, input logic [31:0] as, input logic [31:0] bb, input logic [31:0] bs);
    return ({1'b0, ab} < {1'b0, bb} + {1'b0, bs}) && ({1'b0, bb} < {1'b0, ab} + {1'b0, as});
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational fixed-priority or round-robin one-hot grant
module rr_arbiter #(
  parameter int N = 2,
  parameter int MODE = 0,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);
  int best;
  // Smaller value means higher priority; round-robin rotates so last+1 ranks first
  function automatic int prio(input int j, input logic [LW-1:0] l);
    return (MODE != 0) ? (j + N - 1 - int'(l)) % N : j;
  endfunction
  // Pick the requester with the best rank; ranks are unique so grant is one-hot
  always_comb begin
    best = N;
    for (int j = 0; j < N; j++) if (req[j] && prio(j, last) < best) best = prio(j, last);
    for (int j = 0; j < N; j++) grant[j] = req[j] && (prio(j, last) == best);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: multi-master arbiter and address decoder for ROM/RAM/IO with fault and timeout trapping
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] ROM_SIZE = 32'h0001_0000,
  parameter logic [31:0] RAM_BASE = 32'h8000_0000,
  parameter logic [31:0] RAM_SIZE = 32'h0001_0000,
  parameter logic [31:0] IO_BASE = 32'hF000_0000,
  parameter logic [31:0] IO_SIZE = 32'h0000_0100
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [32*NUM_MASTERS-1:0]      addr_In,
  input  logic [32*NUM_MASTERS-1:0]      data_In,
  input  logic [2*NUM_MASTERS-1:0]       dataWidth_In,
  input  logic [NUM_MASTERS-1:0]         isRead_In,
  input  logic [NUM_MASTERS-1:0]         inputValid_In,
  output logic [NUM_MASTERS-1:0]         operationOK_Out,
  output logic [32*NUM_MASTERS-1:0]      data_Out,
  output logic [EXC_W*NUM_MASTERS-1:0]   exception_Out,
  output logic                           selROM_Out,
  output logic                           selRAM_Out,
  output logic                           selIO_Out,
  output logic [31:0]                    addrSlave_Out,
  output logic [31:0]                    dataSlave_Out,
  output logic [1:0]                     dataWidthSlave_Out,
  output logic                           isReadSlave_Out,
  input  logic                           ROMFinish_In,
  input  logic                           RAMFinish_In,
  input  logic                           IOFinish_In,
  input  logic [31:0]                    ROMData_In,
  input  logic [31:0]                    RAMData_In,
  input  logic [31:0]                    IOData_In,
  input  logic [EXC_W-1:0]               ROMException_In,
  input  logic [EXC_W-1:0]               RAMException_In,
  input  logic [EXC_W-1:0]               IOException_In
);
  localparam int M = NUM_MASTERS;
  localparam int LW = (M > 1) ? $clog2(M) : 1;

  if (overlap(ROM_BASE, ROM_SIZE, RAM_BASE, RAM_SIZE) || overlap(ROM_BASE, ROM_SIZE, IO_BASE, IO_SIZE) ||
      overlap(RAM_BASE, RAM_SIZE, IO_BASE, IO_SIZE)) begin : g_overlap
    $error("mem_arbiter: address regions overlap");
  end

  state_t state;
  logic [LW-1:0] win, last_grant, gidx;
  logic [31:0] cnt, resp_data, gaddr, gdata, gbase, sdata;
  logic [EXC_W-1:0] resp_exc, sexc;
  logic [M-1:0] grant;
  logic [1:0] gwidth;
  logic gread, in_rom, in_ram, in_io, fin;

  // A master acknowledged last cycle is masked so its still-high valid is not re-granted
  rr_arbiter #(.N(M), .MODE(ARB_MODE)) u_arb (
    .req(inputValid_In & ~operationOK_Out),
    .last(last_grant),
    .grant(grant)
  );

  // Route the winning master's request fields and decode its region
  always_comb begin
    gidx = '0;
    gaddr = '0;
    gdata = '0;
    gwidth = '0;
    gread = 1'b0;
    for (int i = 0; i < M; i++) if (grant[i]) begin
      gidx = LW'(i);
      gaddr = addr_In[i*32 +: 32];
      gdata = data_In[i*32 +: 32];
      gwidth = dataWidth_In[i*2 +: 2];
      gread = isRead_In[i];
    end
    in_rom = in_rgn(gaddr, ROM_BASE, ROM_SIZE);
    in_ram = in_rgn(gaddr, RAM_BASE, RAM_SIZE);
    in_io = in_rgn(gaddr, IO_BASE, IO_SIZE);
    gbase = in_rom ? ROM_BASE : in_ram ? RAM_BASE : IO_BASE;
  end

  assign fin = (selROM_Out & ROMFinish_In) | (selRAM_Out & RAMFinish_In) | (selIO_Out & IOFinish_In);
  assign sdata = selROM_Out ? ROMData_In : selRAM_Out ? RAMData_In : IOData_In;
  assign sexc = selROM_Out ? ROMException_In : selRAM_Out ? RAMException_In : IOException_In;

  // Transaction FSM: grant/decode, wait for the selected slave or timeout, then pulse the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      win <= '0;
      last_grant <= LW'(M - 1);
      cnt <= '0;
      resp_data <= '0;
      resp_exc <= EXCEP_OK;
      operationOK_Out <= '0;
      data_Out <= '0;
      exception_Out <= {M{EXCEP_OK}};
      selROM_Out <= 1'b0;
      selRAM_Out <= 1'b0;
      selIO_Out <= 1'b0;
      addrSlave_Out <= '0;
      dataSlave_Out <= '0;
      dataWidthSlave_Out <= '0;
      isReadSlave_Out <= 1'b0;
    end else begin
      operationOK_Out <= '0;
      case (state)
        IDLE: if (|grant) begin
          win <= gidx;
          if (!(in_rom || in_ram || in_io) || gwidth == W_ILLEGAL) begin
            resp_data <= '0;
            resp_exc <= EXCEP_ACCESS_FAULT;
            state <= RESP;
          end else begin
            selROM_Out <= in_rom;
            selRAM_Out <= in_ram;
            selIO_Out <= in_io;
            addrSlave_Out <= gaddr - gbase;
            dataSlave_Out <= gdata;
            dataWidthSlave_Out <= gwidth;
            isReadSlave_Out <= gread;
            cnt <= '0;
            state <= BUSY;
          end
        end
        BUSY: if (fin || (TIMEOUT != 0 && cnt + 32'd1 == 32'(TIMEOUT))) begin
          resp_data <= fin ? sdata : '0;
          resp_exc <= fin ? sexc : EXCEP_BUS_TIMEOUT;
          selROM_Out <= 1'b0;
          selRAM_Out <= 1'b0;
          selIO_Out <= 1'b0;
          state <= RESP;
        end else cnt <= cnt + 32'd1;
        RESP: begin
          for (int i = 0; i < M; i++) if (win == LW'(i)) begin
            operationOK_Out[i] <= 1'b1;
            data_Out[i*32 +: 32] <= resp_data;
            exception_Out[i*EXC_W +: EXC_W] <= resp_exc;
          end
          last_grant <= win;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for a 2-master fixed-priority and a 3-master round-robin arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {int m; logic [31:0] d; logic [3:0] e; int c;} rsp_t;
  typedef struct {int m; logic [31:0] d; logic [3:0] e;} exp_t;
  typedef struct {logic [31:0] addr; logic [1:0] w; logic [3:0] tag; logic [31:0] rel;} acc_t;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0, fails = 0;

  function automatic logic [31:0] sdat(input logic [3:0] tag, input logic [31:0] rel);
    return {tag, 4'h0, rel[23:0]};
  endfunction
  function automatic logic [3:0] sexc_f(input logic [31:0] rel);
    return (rel[3:0] == 4'hC) ? 4'h7 : 4'h0;
  endfunction

  logic [63:0] a_addr = '0, a_wdata = '0, a_dout;
  logic [3:0] a_width = '0;
  logic [1:0] a_read = '0, a_valid = '0, a_ok, a_swidth;
  logic [7:0] a_exc;
  logic a_srom, a_sram, a_sio, a_sread;
  logic [31:0] a_saddr, a_sdata;
  logic a_rom_fin = 0, a_ram_fin = 0, a_io_fin = 0;
  logic [31:0] a_rom_d, a_ram_d, a_io_d;
  logic [3:0] a_rom_e, a_ram_e, a_io_e;

  logic [95:0] b_addr = '0, b_wdata = '0, b_dout;
  logic [5:0] b_width = '0;
  logic [2:0] b_read = '0, b_valid = '0, b_ok;
  logic [11:0] b_exc;
  logic b_srom, b_sram, b_sio, b_sread;
  logic [31:0] b_saddr, b_sdata;
  logic [1:0] b_swidth;
  logic b_rom_fin = 0, b_ram_fin = 0, b_io_fin = 0;
  logic [31:0] b_rom_d, b_ram_d, b_io_d;
  logic [3:0] b_rom_e, b_ram_e, b_io_e;

  assign a_rom_d = sdat(4'h1, a_saddr);
  assign a_ram_d = sdat(4'h2, a_saddr);
  assign a_io_d = sdat(4'h3, a_saddr);
  assign a_rom_e = sexc_f(a_saddr);
  assign a_ram_e = sexc_f(a_saddr);
  assign a_io_e = sexc_f(a_saddr);
  assign b_rom_d = sdat(4'h1, b_saddr);
  assign b_ram_d = sdat(4'h2, b_saddr);
  assign b_io_d = sdat(4'h3, b_saddr);
  assign b_rom_e = sexc_f(b_saddr);
  assign b_ram_e = sexc_f(b_saddr);
  assign b_io_e = sexc_f(b_saddr);

  mem_arbiter #(.NUM_MASTERS(2), .ARB_MODE(0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .addr_In(a_addr), .data_In(a_wdata), .dataWidth_In(a_width),
    .isRead_In(a_read), .inputValid_In(a_valid), .operationOK_Out(a_ok), .data_Out(a_dout),
    .exception_Out(a_exc), .selROM_Out(a_srom), .selRAM_Out(a_sram), .selIO_Out(a_sio),
    .addrSlave_Out(a_saddr), .dataSlave_Out(a_sdata), .dataWidthSlave_Out(a_swidth),
    .isReadSlave_Out(a_sread), .ROMFinish_In(a_rom_fin), .RAMFinish_In(a_ram_fin),
    .IOFinish_In(a_io_fin), .ROMData_In(a_rom_d), .RAMData_In(a_ram_d), .IOData_In(a_io_d),
    .ROMException_In(a_rom_e), .RAMException_In(a_ram_e), .IOException_In(a_io_e));

  mem_arbiter #(.NUM_MASTERS(3), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .addr_In(b_addr), .data_In(b_wdata), .dataWidth_In(b_width),
    .isRead_In(b_read), .inputValid_In(b_valid), .operationOK_Out(b_ok), .data_Out(b_dout),
    .exception_Out(b_exc), .selROM_Out(b_srom), .selRAM_Out(b_sram), .selIO_Out(b_sio),
    .addrSlave_Out(b_saddr), .dataSlave_Out(b_sdata), .dataWidthSlave_Out(b_swidth),
    .isReadSlave_Out(b_sread), .ROMFinish_In(b_rom_fin), .RAMFinish_In(b_ram_fin),
    .IOFinish_In(b_io_fin), .ROMData_In(b_rom_d), .RAMData_In(b_ram_d), .IOData_In(b_io_d),
    .ROMException_In(b_rom_e), .RAMException_In(b_ram_e), .IOException_In(b_io_e));

  int a_lat = 0, a_bcnt = 0, b_bcnt = 0, a_selcyc = 0;
  bit a_hang = 0, a_stray = 0, a_selseen = 0;
  rsp_t a_got[$], b_got[$];
  exp_t a_exp[$], b_exp[$];

  // Slave models: finish the selected slave after a_lat busy cycles; a_stray pulses an unselected IO finish
  always @(negedge clk) begin
    bit fire;
    fire = (a_srom | a_sram | a_sio) && !a_hang && a_bcnt == a_lat;
    a_bcnt = (a_srom | a_sram | a_sio) ? a_bcnt + 1 : 0;
    a_rom_fin = a_srom & fire;
    a_ram_fin = a_sram & fire;
    a_io_fin = (a_sio & fire) | a_stray;
    b_rom_fin = b_srom && b_bcnt == 0;
    b_ram_fin = b_sram && b_bcnt == 0;
    b_io_fin = b_sio && b_bcnt == 0;
    b_bcnt = (b_srom | b_sram | b_sio) ? b_bcnt + 1 : 0;
  end

  // Response collectors
  always @(negedge clk) begin
    if (a_srom | a_sram | a_sio) begin
      a_selcyc++;
      a_selseen = 1;
    end
    for (int i = 0; i < 2; i++) if (a_ok[i]) a_got.push_back('{i, a_dout[i*32 +: 32], a_exc[i*4 +: 4], cyc});
    for (int i = 0; i < 3; i++) if (b_ok[i]) b_got.push_back('{i, b_dout[i*32 +: 32], b_exc[i*4 +: 4], cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic a_wait(input int n, input int budget, output bit done);
    int k = 0;
    while (a_got.size() < n && k < budget) begin
      step();
      a_valid = a_valid & ~a_ok;
      k++;
    end
    done = a_got.size() >= n;
  endtask

  task automatic b_wait(input int n, input int budget, output bit done);
    int k = 0;
    while (b_got.size() < n && k < budget) begin
      step();
      k++;
    end
    done = b_got.size() >= n;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) step();
    tests++;
    if ({a_ok, a_srom, a_sram, a_sio, a_dout, a_exc} !== '0) begin
      fails++;
      $display("FAIL reset_a_outputs: got ok=%b sel=%b%b%b dout=%h exc=%h expected all zero", a_ok, a_srom, a_sram, a_sio, a_dout, a_exc);
    end
    tests++;
    if ({a_saddr, a_sdata, a_swidth, a_sread} !== '0) begin
      fails++;
      $display("FAIL reset_a_slave_fields: got addr=%h data=%h w=%h rd=%b expected 0", a_saddr, a_sdata, a_swidth, a_sread);
    end
    tests++;
    if ({b_ok, b_srom, b_sram, b_sio, b_dout, b_exc} !== '0) begin
      fails++;
      $display("FAIL reset_b_outputs: got ok=%b dout=%h exc=%h expected all zero", b_ok, b_dout, b_exc);
    end
    rst = 0;
    step();
  endtask

  task automatic test_fixed_priority();
    bit done;
    int t0, c0;
    rsp_t g;
    exp_t e;
    a_got.delete();
    a_exp.delete();
    a_addr = {2{32'h8000_0010}};
    a_read = 2'b11;
    a_width = {2{W_WORD}};
    a_valid = 2'b11;
    t0 = cyc;
    a_exp.push_back('{0, sdat(4'h2, 32'h10), 4'h0});
    a_exp.push_back('{1, sdat(4'h2, 32'h10), 4'h0});
    step();
    tests++;
    if ({a_srom, a_sram, a_sio, a_saddr, a_sread} !== {3'b010, 32'h10, 1'b1}) begin
      fails++;
      $display("FAIL prio_first_select: got sel=%b%b%b addr=%h rd=%b expected 010 00000010 1", a_srom, a_sram, a_sio, a_saddr, a_sread);
    end
    a_wait(2, 20, done);
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL prio_wait: got %0d responses expected 2", a_got.size());
    end
    c0 = 0;
    for (int i = 0; i < 2 && a_got.size() > 0; i++) begin
      g = a_got.pop_front();
      e = a_exp.pop_front();
      tests++;
      if (g.m !== e.m || g.d !== e.d || g.e !== e.e) begin
        fails++;
        $display("FAIL prio_resp%0d: got m=%0d d=%h e=%h expected m=%0d d=%h e=%h", i, g.m, g.d, g.e, e.m, e.d, e.e);
      end
      tests++;
      if (g.c !== (i == 0 ? t0 + 3 : c0 + 3)) begin
        fails++;
        $display("FAIL prio_timing%0d: got cycle %0d expected %0d", i, g.c, i == 0 ? t0 + 3 : c0 + 3);
      end
      c0 = g.c;
    end
    step();
    tests++;
    if (a_dout !== {2{sdat(4'h2, 32'h10)}}) begin
      fails++;
      $display("FAIL prio_held_data: got %h expected %h", a_dout, {2{sdat(4'h2, 32'h10)}});
    end
  endtask

  task automatic test_access_map();
    acc_t tbl [8];
    bit done, fault;
    int t0;
    rsp_t g;
    exp_t e;
    tbl = '{'{32'h4000_0000, 2'd2, 4'h0, 32'h0}, '{32'h8000_0040, 2'd3, 4'h0, 32'h0},
            '{32'h0000_FFFF, 2'd0, 4'h1, 32'hFFFF}, '{32'h0001_0000, 2'd2, 4'h0, 32'h0},
            '{32'h8000_FFFC, 2'd2, 4'h2, 32'hFFFC}, '{32'hF000_00FF, 2'd0, 4'h3, 32'hFF},
            '{32'hF000_0100, 2'd0, 4'h0, 32'h0}, '{32'h7FFF_FFFF, 2'd2, 4'h0, 32'h0}};
    a_lat = 0;
    for (int i = 0; i < 8; i++) begin
      a_got.delete();
      a_exp.delete();
      fault = tbl[i].tag == 4'h0;
      a_addr[31:0] = tbl[i].addr;
      a_width[1:0] = tbl[i].w;
      a_read[0] = 1'b1;
      a_valid[0] = 1'b1;
      a_selseen = 0;
      t0 = cyc;
      a_exp.push_back('{0, fault ? 32'h0 : sdat(tbl[i].tag, tbl[i].rel), fault ? EXCEP_ACCESS_FAULT : sexc_f(tbl[i].rel)});
      a_wait(1, 20, done);
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL map%0d_wait: got no response expected one", i);
      end else begin
        g = a_got.pop_front();
        e = a_exp.pop_front();
        tests++;
        if (g.m !== e.m || g.d !== e.d || g.e !== e.e) begin
          fails++;
          $display("FAIL map%0d_resp: got m=%0d d=%h e=%h expected m=%0d d=%h e=%h", i, g.m, g.d, g.e, e.m, e.d, e.e);
        end
        tests++;
        if (g.c !== t0 + (fault ? 2 : 3)) begin
          fails++;
          $display("FAIL map%0d_latency: got %0d expected %0d", i, g.c - t0, fault ? 2 : 3);
        end
        tests++;
        if (a_selseen !== !fault) begin
          fails++;
          $display("FAIL map%0d_select: got %b expected %b", i, a_selseen, !fault);
        end
      end
      step();
    end
  endtask

  task automatic test_timeout();
    bit done;
    int t0;
    rsp_t g;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      a_got.delete();
      a_exp.delete();
      a_hang = i == 0;
      a_stray = i == 0;
      a_lat = 3;
      a_addr[31:0] = i == 0 ? 32'h0000_0100 : 32'h0000_0020;
      a_width[1:0] = W_WORD;
      a_read[0] = 1'b1;
      a_valid[0] = 1'b1;
      a_selcyc = 0;
      t0 = cyc;
      a_exp.push_back(i == 0 ? '{0, 32'h0, EXCEP_BUS_TIMEOUT} : '{0, sdat(4'h1, 32'h20), EXCEP_OK});
      a_wait(1, 30, done);
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL timeout%0d_wait: got no response expected one", i);
      end else begin
        g = a_got.pop_front();
        e = a_exp.pop_front();
        tests++;
        if (g.m !== e.m || g.d !== e.d || g.e !== e.e) begin
          fails++;
          $display("FAIL timeout%0d_resp: got m=%0d d=%h e=%h expected m=%0d d=%h e=%h", i, g.m, g.d, g.e, e.m, e.d, e.e);
        end
        tests++;
        if (g.c !== t0 + 6 || a_selcyc !== 4) begin
          fails++;
          $display("FAIL timeout%0d_cycles: got latency %0d sel cycles %0d expected 6 and 4", i, g.c - t0, a_selcyc);
        end
      end
      a_hang = 0;
      a_stray = 0;
      step();
    end
    a_lat = 0;
  endtask

  task automatic test_write_hold();
    bit done;
    rsp_t g;
    exp_t e;
    a_got.delete();
    a_exp.delete();
    a_lat = 2;
    a_addr[63:32] = 32'h8000_0200;
    a_wdata[63:32] = 32'h0000_1234;
    a_width[3:2] = W_HALF;
    a_read[1] = 1'b0;
    a_valid[1] = 1'b1;
    a_exp.push_back('{1, sdat(4'h2, 32'h200), 4'h0});
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({a_srom, a_sram, a_sio, a_saddr, a_sdata, a_swidth, a_sread} !== {3'b010, 32'h200, 32'h1234, W_HALF, 1'b0}) begin
        fails++;
        $display("FAIL write_fields%0d: got sel=%b%b%b addr=%h data=%h w=%h rd=%b expected 010 200 1234 1 0", i, a_srom, a_sram, a_sio, a_saddr, a_sdata, a_swidth, a_sread);
      end
    end
    a_wait(1, 20, done);
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL write_wait: got no response expected one");
    end else begin
      g = a_got.pop_front();
      e = a_exp.pop_front();
      tests++;
      if (g.m !== e.m || g.d !== e.d || g.e !== e.e) begin
        fails++;
        $display("FAIL write_resp: got m=%0d d=%h e=%h expected m=%0d d=%h e=%h", g.m, g.d, g.e, e.m, e.d, e.e);
      end
    end
    tests++;
    if (a_dout[31:0] !== sdat(4'h1, 32'h20) || a_exc[3:0] !== EXCEP_OK) begin
      fails++;
      $display("FAIL write_other_held: got d=%h e=%h expected d=%h e=0", a_dout[31:0], a_exc[3:0], sdat(4'h1, 32'h20));
    end
    a_lat = 0;
    step();
  endtask

  task automatic test_round_robin();
    bit done;
    int c0;
    rsp_t g;
    exp_t e;
    b_got.delete();
    b_exp.delete();
    b_addr = {32'h8000_0108, 32'h8000_0104, 32'h8000_0100};
    b_read = 3'b111;
    b_width = {3{W_WORD}};
    b_valid = 3'b111;
    foreach (b_exp[i]) b_exp.delete();
    for (int i = 0; i < 4; i++) b_exp.push_back('{i % 3, sdat(4'h2, 32'h100 + 32'(4 * (i % 3))), 4'h0});
    b_wait(4, 40, done);
    b_valid = 3'b000;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL rr_wait: got %0d responses expected 4", b_got.size());
    end
    c0 = 0;
    for (int i = 0; i < 4 && b_got.size() > 0; i++) begin
      g = b_got.pop_front();
      e = b_exp.pop_front();
      tests++;
      if (g.m !== e.m || g.d !== e.d || g.e !== e.e) begin
        fails++;
        $display("FAIL rr_order%0d: got m=%0d d=%h e=%h expected m=%0d d=%h e=%h", i, g.m, g.d, g.e, e.m, e.d, e.e);
      end
      if (i > 0) begin
        tests++;
        if (g.c !== c0 + 3) begin
          fails++;
          $display("FAIL rr_spacing%0d: got %0d expected 3", i, g.c - c0);
        end
      end
      c0 = g.c;
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid_busy();
    a_got.delete();
    a_hang = 1;
    a_addr[31:0] = 32'hF000_0004;
    a_wdata[31:0] = 32'hDEAD_BEEF;
    a_width[1:0] = W_WORD;
    a_read[0] = 1'b0;
    a_valid[0] = 1'b1;
    step();
    tests++;
    if ({a_sio, a_saddr, a_sdata} !== {1'b1, 32'h4, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL rstbusy_select: got io=%b addr=%h data=%h expected 1 4 deadbeef", a_sio, a_saddr, a_sdata);
    end
    rst = 1;
    step();
    tests++;
    if ({a_ok, a_srom, a_sram, a_sio, a_dout, a_exc, a_saddr, a_sdata, a_swidth, a_sread} !== '0) begin
      fails++;
      $display("FAIL rstbusy_outputs: got ok=%b sel=%b%b%b dout=%h exc=%h saddr=%h sdata=%h expected all zero", a_ok, a_srom, a_sram, a_sio, a_dout, a_exc, a_saddr, a_sdata);
    end
    rst = 0;
    a_valid = 2'b00;
    a_hang = 0;
    repeat (8) step();
    tests++;
    if (a_got.size() !== 0) begin
      fails++;
      $display("FAIL rstbusy_no_ok: got %0d responses expected 0", a_got.size());
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_access_map();
    test_timeout();
    test_write_hold();
    test_round_robin();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
